// File: rtl/grid_square_plot_ctrl.sv
// grid_square_plot_ctrl
// Starts the 20x20 grid-square drawer for one requested cell, opens an
// exact SQ_PIXELS-cycle plot window onto the VGA adapter, then reports
// completion (ack) and whether the drawer finished cleanly (err).
module grid_square_plot_ctrl #(
  parameter int GRID_COLS = 8,
  parameter int GRID_ROWS = 6,
  parameter int SQ_PIXELS = 400
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req,
  input  logic       cancel,
  input  logic [3:0] GRID_X,
  input  logic [3:0] GRID_Y,
  output logic [3:0] COUNTER_X,
  output logic [3:0] COUNTER_Y,
  output logic       drawer_resetn,
  input  logic [7:0] draw_x,
  input  logic [6:0] draw_y,
  input  logic [8:0] draw_colour,
  input  logic       square_done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [8:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       ack,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLOT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [3:0] COLS_LIM = 4'(GRID_COLS);
  localparam logic [3:0] ROWS_LIM = 4'(GRID_ROWS);
  localparam logic [8:0] PIX_LAST = 9'(SQ_PIXELS - 1);

  state_t     state;
  logic [8:0] pix_cnt;
  logic       in_range;

  assign in_range = (GRID_X < COLS_LIM) && (GRID_Y < ROWS_LIM);

  // The drawer's pixel stream goes straight through; plot gates the write.
  assign vga_x      = draw_x;
  assign vga_y      = draw_y;
  assign vga_colour = draw_colour;
  assign plot       = (state == PLOT);

  // Sequencer: all outputs other than plot are registered alongside state so
  // they change exactly when the state they belong to is entered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      COUNTER_X     <= 4'd0;
      COUNTER_Y     <= 4'd0;
      pix_cnt       <= 9'd0;
      drawer_resetn <= 1'b0;
      busy          <= 1'b0;
      ack           <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (req) begin
            busy <= 1'b1;
            if (in_range) begin
              COUNTER_X     <= GRID_X;
              COUNTER_Y     <= GRID_Y;
              drawer_resetn <= 1'b1;
              state         <= PRIME;
            end else begin
              // Bad coordinates: answer at once, drawer never released.
              ack   <= 1'b1;
              err   <= 1'b1;
              state <= ACK;
            end
          end
        end
        PRIME: begin
          // One cycle to let the drawer's ROM output line up with pixel 0.
          pix_cnt <= 9'd0;
          if (cancel) begin
            drawer_resetn <= 1'b0;
            ack           <= 1'b1;
            err           <= 1'b1;
            state         <= ACK;
          end else begin
            state <= PLOT;
          end
        end
        PLOT: begin
          if (cancel) begin
            // Abort wins over the terminal-count check.
            pix_cnt       <= 9'd0;
            drawer_resetn <= 1'b0;
            ack           <= 1'b1;
            err           <= 1'b1;
            state         <= ACK;
          end else if (pix_cnt == PIX_LAST) begin
            pix_cnt       <= 9'd0;
            drawer_resetn <= 1'b0;
            ack           <= 1'b1;
            err           <= ~square_done;
            state         <= ACK;
          end else begin
            pix_cnt <= pix_cnt + 9'd1;
          end
        end
        ACK: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state         <= IDLE;
          drawer_resetn <= 1'b0;
          busy          <= 1'b0;
          ack           <= 1'b0;
          err           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_square_plot_ctrl.sv
// Bench for grid_square_plot_ctrl: a drawer model feeds the pixel stream,
// the stimulus pushes expected pixels and acks into queues, and a monitor
// pops and compares whenever plot or ack is seen.
module tb_grid_square_plot_ctrl;

  localparam int SQ = 400;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] gx = 4'd0;
  logic [3:0] gy = 4'd0;
  logic [3:0] COUNTER_X, COUNTER_Y;
  logic       drawer_resetn;
  logic [7:0] draw_x = 8'd0;
  logic [6:0] draw_y = 7'd0;
  logic [8:0] draw_colour = 9'd0;
  logic       square_done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [8:0] vga_colour;
  logic       plot, busy, ack, err;

  grid_square_plot_ctrl dut (
    .clk(clk), .resetn(resetn), .req(req), .cancel(cancel),
    .GRID_X(gx), .GRID_Y(gy), .COUNTER_X(COUNTER_X), .COUNTER_Y(COUNTER_Y),
    .drawer_resetn(drawer_resetn), .draw_x(draw_x), .draw_y(draw_y),
    .draw_colour(draw_colour), .square_done(square_done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  // Period index: value seen after each rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] colour_of(int k);
    return 9'((k * 37 + 5) % 512);
  endfunction

  // Drawer model: counts pixels while released, outputs with one cycle of
  // ROM latency, raises done once all pixels have been walked.
  int   dcnt = 0;
  logic done_en = 1'b1;
  always @(posedge clk) begin
    if (!drawer_resetn) dcnt <= 0;
    else if (dcnt < SQ) dcnt <= dcnt + 1;
    draw_x      <= 8'(20 * int'(COUNTER_X) + dcnt % 20);
    draw_y      <= 7'(20 * int'(COUNTER_Y) + dcnt / 20);
    draw_colour <= colour_of(dcnt);
  end
  assign square_done = done_en && (dcnt >= SQ);

  typedef struct { int x; int y; int c; } pix_t;
  typedef struct { int err; int ack_cyc; int first_cyc; } ack_t;
  pix_t pix_q[$];
  ack_t ack_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what a request issued during period p must produce.
  task automatic push_model(int x, int y, int p, int cancel_k, bit done_ok);
    ack_t a;
    pix_t e;
    int last;
    if (x >= 8 || y >= 6) begin
      a = '{1, p + 1, -1};
    end else begin
      last = (cancel_k >= 0) ? cancel_k : SQ - 1;
      for (int k = 0; k <= last; k++) begin
        e = '{20 * x + k % 20, 20 * y + k / 20, int'(colour_of(k))};
        pix_q.push_back(e);
      end
      a.err       = (cancel_k >= 0 || !done_ok) ? 1 : 0;
      a.ack_cyc   = p + 3 + last;
      a.first_cyc = p + 2;
    end
    ack_q.push_back(a);
  endtask

  // Monitor.
  int first_seen = -1;
  bit chk_idle = 0;
  always @(posedge clk) begin
    pix_t e;
    ack_t a;
    #1;
    if (!resetn) begin
      first_seen = -1;
      chk_idle = 0;
    end else begin
      if (chk_idle) begin
        chk("busy_after_ack", int'(busy), 0);
        chk("drvrst_after_ack", int'(drawer_resetn), 0);
        chk_idle = 0;
      end
      if (plot) begin
        if (first_seen < 0) first_seen = cyc;
        if (pix_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_plot: plot=1 with no pixel expected (cycle %0d)", cyc);
        end else begin
          e = pix_q.pop_front();
          chk("vga_x", int'(vga_x), e.x);
          chk("vga_y", int'(vga_y), e.y);
          chk("vga_colour", int'(vga_colour), e.c);
          chk("drvrst_in_plot", int'(drawer_resetn), 1);
        end
      end
      if (ack) begin
        if (ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_ack: ack=1 with no ack expected (cycle %0d)", cyc);
        end else begin
          a = ack_q.pop_front();
          chk("ack_err", int'(err), a.err);
          chk("ack_cycle", cyc, a.ack_cyc);
          chk("first_plot_cycle", first_seen, a.first_cyc);
          chk("pixels_left", pix_q.size(), 0);
          chk("busy_in_ack", int'(busy), 1);
          chk("drvrst_in_ack", int'(drawer_resetn), 0);
          $display("ack cycle=%0d err=%0d first_plot=%0d", cyc, err, first_seen);
        end
        first_seen = -1;
        chk_idle = 1;
      end else begin
        chk("err_without_ack", int'(err), 0);
      end
    end
  end

  // One request with optional cancel point, done-missing, and a busy req.
  task automatic do_draw(int x, int y, int cancel_k, bit done_ok, bit busy_req);
    int p, fin, n;
    bit inr;
    inr = (x < 8 && y < 6);
    @(negedge clk);
    done_en = done_ok;
    gx = 4'(x);
    gy = 4'(y);
    req = 1'b1;
    cancel = 1'($urandom_range(0, 1));  // simultaneous cancel must not block req
    p = cyc;
    push_model(x, y, p, cancel_k, done_ok);
    $display("req (%0d,%0d) period=%0d cancel_at=%0d done_ok=%0d busy_req=%0d",
             x, y, p, cancel_k, done_ok, busy_req);
    fin = !inr ? p + 1 : (cancel_k >= 0 ? p + 3 + cancel_k : p + 402);
    while (cyc <= fin + 1) begin
      @(negedge clk);
      req    = (busy_req && cyc == p + 50) ? 1'b1 : 1'b0;
      cancel = (cancel_k >= 0 && cyc == p + 2 + cancel_k) ? 1'b1 : 1'b0;
      if (cyc == p + 50) begin
        gx = 4'd0;
        gy = 4'd0;
      end else begin
        gx = 4'($urandom);
        gy = 4'($urandom);
      end
      if (!inr) chk("oor_drvrst", int'(drawer_resetn), 0);
    end
    req = 1'b0;
    cancel = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_after_draw", int'(busy), 0);
    chk("queues_drained", pix_q.size() + ack_q.size(), 0);
    // Idle gap with a stray cancel that must be ignored.
    cancel = 1'($urandom_range(0, 1));
    repeat ($urandom_range(1, 3)) @(negedge clk);
    cancel = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_drvrst", int'(drawer_resetn), 0);
    chk("rst_cx", int'(COUNTER_X), 0);
    chk("rst_cy", int'(COUNTER_Y), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    do_draw(3, 2, -1, 1'b1, 1'b1);   // normal draw plus ignored busy req
    do_draw(8, 0, -1, 1'b1, 1'b0);   // column out of range
    do_draw(1, 1, -1, 1'b0, 1'b0);   // drawer never reports done
    do_draw(2, 4, 100, 1'b1, 1'b0);  // cancel at pix_cnt 100
    do_draw(5, 5, -1, 1'b1, 1'b0);
    do_draw(0, 0, 0, 1'b1, 1'b0);    // cancel on first plot cycle
    do_draw(4, 1, 399, 1'b1, 1'b0);  // cancel beats terminal count

    // Asynchronous reset in the middle of a draw.
    @(negedge clk);
    gx = 4'd4;
    gy = 4'd3;
    req = 1'b1;
    push_model(4, 3, cyc, -1, 1'b1);
    @(negedge clk);
    req = 1'b0;
    repeat (100) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_plot", int'(plot), 0);
    chk("arst_drvrst", int'(drawer_resetn), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_cx", int'(COUNTER_X), 0);
    $display("async reset applied mid-plot at cycle %0d", cyc);
    pix_q.delete();
    ack_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    do_draw(7, 5, -1, 1'b1, 1'b0);   // last pixel at (159,119)
    do_draw(0, 6, -1, 1'b1, 1'b0);   // row out of range
    do_draw(15, 15, -1, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      int x, y, ck;
      bit dn, br;
      x  = $urandom_range(0, 9);
      y  = $urandom_range(0, 7);
      ck = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 399)) : -1;
      dn = ($urandom_range(0, 4) != 0);
      br = (ck < 0 || ck > 50) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_draw(x, y, ck, dn, br);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
